// File: rtl/seg7_scan_driver.sv
// Time-multiplexed NDIGIT 7-segment scanner with frame-boundary buffered updates.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_scan_driver #(
    parameter int NDIGIT = 8,
    parameter int DIV    = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*NDIGIT-1:0]   value_in,
    input  logic [NDIGIT-1:0]     dp_in,
    output logic [NDIGIT-1:0]     digit_sel,
    output logic [3:0]            nibble,
    output logic                  dp,
    output logic                  frame_start
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;

    typedef struct packed {
        logic [4*NDIGIT-1:0] val;
        logic [NDIGIT-1:0]   dp;
    } frame_t;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   presc, presc_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    frame_t          disp, disp_nxt, pend, pend_nxt, in_f, src;
    logic            pend_v, pend_v_nxt;
    logic            tick, boundary;
    logic [NDIGIT-1:0] blank;
    logic [NDIGIT-1:0] sel_nxt;
    logic [3:0]      nib_nxt;
    logic            dp_nxt, fs_nxt;

    assign in_f = '{val: value_in, dp: dp_in};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            presc       <= '0;
            idx         <= '0;
            disp        <= '0;
            pend        <= '0;
            pend_v      <= 1'b0;
            digit_sel   <= '0;
            nibble      <= '0;
            dp          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            presc       <= presc_nxt;
            idx         <= idx_nxt;
            disp        <= disp_nxt;
            pend        <= pend_nxt;
            pend_v      <= pend_v_nxt;
            digit_sel   <= sel_nxt;
            nibble      <= nib_nxt;
            dp          <= dp_nxt;
            frame_start <= fs_nxt;
        end
    end

    // Frame boundary is the first tick out of IDLE or the tick after the last digit.
    always_comb begin
        tick       = en && (presc == PW'(DIV - 1));
        boundary   = tick && ((state == IDLE) || (idx == IW'(NDIGIT - 1)));
        src        = load ? in_f : (pend_v ? pend : disp);
        state_nxt  = state;
        idx_nxt    = idx;
        disp_nxt   = disp;
        pend_nxt   = pend;
        pend_v_nxt = pend_v;
        presc_nxt  = tick ? '0 : presc + PW'(1);
        if (!en) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            presc_nxt = '0;
        end else if (tick) begin
            state_nxt = SCAN;
            if (boundary) begin
                idx_nxt  = '0;
                disp_nxt = src;
            end else begin
                idx_nxt = idx + IW'(1);
            end
        end
        if (boundary) begin
            pend_v_nxt = 1'b0;
        end else if (load) begin
            pend_nxt   = in_f;
            pend_v_nxt = 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign blank[0] = 1'b0;
    for (genvar i = 1; i < NDIGIT; i++) begin : g_blank
        assign blank[i] = ~|{disp_nxt.val[4*NDIGIT-1:4*i], disp_nxt.dp[NDIGIT-1:i]};
    end
`else
    assign blank = '0;
`endif

    // Outputs follow the new index/frame on the same edge; hold between ticks.
    always_comb begin
        sel_nxt = digit_sel;
        nib_nxt = nibble;
        dp_nxt  = dp;
        fs_nxt  = boundary;
        if (!en) begin
            sel_nxt = '0;
            nib_nxt = '0;
            dp_nxt  = 1'b0;
        end else if (tick) begin
            if (blank[idx_nxt]) begin
                sel_nxt = '0;
                nib_nxt = '0;
                dp_nxt  = 1'b0;
            end else begin
                sel_nxt = NDIGIT'(1) << idx_nxt;
                nib_nxt = disp_nxt.val[4*idx_nxt +: 4];
                dp_nxt  = disp_nxt.dp[idx_nxt];
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at NDIGIT=4, DIV=4.
// Expectations for the blanking case follow LEADING_ZERO_BLANK_EN.
module tb_seg7_scan_driver;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_sel;
    logic [3:0]  nibble;
    logic        dp;
    logic        frame_start;
    int          total = 0;
    int          bad = 0;

    seg7_scan_driver #(.NDIGIT(4), .DIV(4)) dut (
        .clock(clock), .reset(reset), .en(en), .load(load),
        .value_in(value_in), .dp_in(dp_in),
        .digit_sel(digit_sel), .nibble(nibble), .dp(dp), .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Packed observation: {digit_sel, nibble, dp, frame_start}
    task automatic chk(input string tag, input logic [3:0] sel, input logic [3:0] nib,
                       input logic d, input logic fs);
        logic [9:0] obs, exp;
        obs = {digit_sel, nibble, dp, frame_start};
        exp = {sel, nib, d, fs};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed sel=%b nib=%h dp=%b fs=%b expected sel=%b nib=%h dp=%b fs=%b",
                   tag, obs[9:6], obs[5:2], obs[1], obs[0], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    always @(negedge clock) begin
        if (reset && digit_sel != 4'b0) begin
            total++;
            assert ($onehot(digit_sel)) else begin
                bad++;
                $error("FAIL onehot observed sel=%b expected one bit", digit_sel);
            end
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        load = 1'b1; value_in = v; dp_in = d;
    endtask

    initial begin
        // reset state
        cyc(2);
        chk("reset", 4'b0000, 4'h0, 1'b0, 1'b0);
        reset = 1'b1; en = 1'b1;                           // release: edge 0
        // 1: first frame
        cyc(1); do_load(16'h12AB, 4'b0000);                // captured at edge 2
        cyc(1); load = 1'b0;
        cyc(1); chk("idle_dark", 4'b0000, 4'h0, 1'b0, 1'b0);  // edge 3
        cyc(1); chk("d0_first", 4'b0001, 4'hB, 1'b0, 1'b1);   // edge 4
        cyc(1); chk("d0_hold", 4'b0001, 4'hB, 1'b0, 1'b0);    // edge 5
        cyc(3); chk("d1", 4'b0010, 4'hA, 1'b0, 1'b0);         // edge 8
        cyc(4); chk("d2", 4'b0100, 4'h2, 1'b0, 1'b0);         // edge 12
        cyc(4); chk("d3", 4'b1000, 4'h1, 1'b0, 1'b0);         // edge 16
        cyc(4); chk("frame2_d0", 4'b0001, 4'hB, 1'b0, 1'b1);  // edge 20
        // 2: mid-frame load buffered until next boundary
        do_load(16'h5555, 4'b0000);
        cyc(1); load = 1'b0;                               // edge 21
        cyc(3); chk("nt_d1", 4'b0010, 4'hA, 1'b0, 1'b0);      // edge 24
        cyc(8); chk("nt_d3", 4'b1000, 4'h1, 1'b0, 1'b0);      // edge 32
        cyc(4); chk("new5_d0", 4'b0001, 4'h5, 1'b0, 1'b1);    // edge 36
        cyc(4); chk("new5_d1", 4'b0010, 4'h5, 1'b0, 1'b0);    // edge 40
        do_load(16'h1111, 4'b0000);
        cyc(1); load = 1'b0;                               // edge 41
        cyc(1); do_load(16'h7654, 4'b0000);                // edge 42
        cyc(1); load = 1'b0;                               // edge 43
        cyc(5); chk("two_old_d3", 4'b1000, 4'h5, 1'b0, 1'b0); // edge 48
        cyc(4); chk("last_d0", 4'b0001, 4'h4, 1'b0, 1'b1);    // edge 52
        cyc(4); chk("last_d1", 4'b0010, 4'h5, 1'b0, 1'b0);    // edge 56
        // 3: load coincident with boundary tick (edge 68)
        cyc(11); do_load(16'h9ABC, 4'b0001);               // edge 67
        cyc(1); load = 1'b0;
        chk("coinc_d0", 4'b0001, 4'hC, 1'b1, 1'b1);           // edge 68
        cyc(4); chk("coinc_d1", 4'b0010, 4'hB, 1'b0, 1'b0);   // edge 72
        cyc(12); chk("nopend_d0", 4'b0001, 4'hC, 1'b1, 1'b1); // edge 84
        // 4: en drop during digit 2
        cyc(9); en = 1'b0;                                 // edge 93
        cyc(1); chk("en0_dark", 4'b0000, 4'h0, 1'b0, 1'b0);   // edge 94
        cyc(2); chk("en0_hold", 4'b0000, 4'h0, 1'b0, 1'b0);   // edge 96
        en = 1'b1;
        cyc(3); chk("en1_wait", 4'b0000, 4'h0, 1'b0, 1'b0);   // edge 99
        cyc(1); chk("en1_d0", 4'b0001, 4'hC, 1'b1, 1'b1);     // edge 100
        // 5: asynchronous reset between edges
        cyc(5); chk("pre_rst", 4'b0010, 4'hB, 1'b0, 1'b0);    // edge 105
        #2 reset = 1'b0;
        #1 chk("async_rst", 4'b0000, 4'h0, 1'b0, 1'b0);
        cyc(1); reset = 1'b1;                              // release: edge 0
        // 6: leading-zero handling
        do_load(16'h0030, 4'b0000);                        // captured at edge 1
        cyc(1); load = 1'b0;
        cyc(3); chk("lz_d0", 4'b0001, 4'h0, 1'b0, 1'b1);      // edge 4
        cyc(4); chk("lz_d1", 4'b0010, 4'h3, 1'b0, 1'b0);      // edge 8
`ifdef LEADING_ZERO_BLANK_EN
        cyc(4); chk("lz_d2", 4'b0000, 4'h0, 1'b0, 1'b0);      // edge 12
        cyc(4); chk("lz_d3", 4'b0000, 4'h0, 1'b0, 1'b0);      // edge 16
`else
        cyc(4); chk("lz_d2", 4'b0100, 4'h0, 1'b0, 1'b0);
        cyc(4); chk("lz_d3", 4'b1000, 4'h0, 1'b0, 1'b0);
`endif
        do_load(16'h0000, 4'b0100);                        // captured at edge 17
        cyc(1); load = 1'b0;
        cyc(3); chk("dp_d0", 4'b0001, 4'h0, 1'b0, 1'b1);      // edge 20
        cyc(4); chk("dp_d1", 4'b0010, 4'h0, 1'b0, 1'b0);      // edge 24
        cyc(4); chk("dp_d2", 4'b0100, 4'h0, 1'b1, 1'b0);      // edge 28
`ifdef LEADING_ZERO_BLANK_EN
        cyc(4); chk("dp_d3", 4'b0000, 4'h0, 1'b0, 1'b0);      // edge 32
`else
        cyc(4); chk("dp_d3", 4'b1000, 4'h0, 1'b0, 1'b0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
